// File: rtl/frame_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// frame_sequencer : frame-level fetch-reset / drain / framebuffer-switch control
// Revision 1.0 - initial release
// =============================================================================
module frame_sequencer #(
  parameter int TIMER_WIDTH  = 22,
  parameter int FRAME_PERIOD = 2_000_000,
  parameter int MIN_PERIOD   = 1_000,
  parameter int DRAIN_CYCLES = 16,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   mode_in,
  input  logic                   framebuffer_ready_in,
  input  logic                   fetch_done_in,
  input  logic                   pipeline_busy_in,
  input  logic                   pixel_valid_in,
  output logic                   fetch_rst_out,
  output logic                   framebuffer_switch_out,
  output logic                   framebuffer_clear_out,
  output logic [COUNT_WIDTH-1:0] frame_count_out,
  output logic [COUNT_WIDTH-1:0] pixel_count_out,
  output logic [COUNT_WIDTH-1:0] overrun_count_out,
  output logic [2:0]             state_out
);

  typedef enum logic [2:0] {
    S_WAIT_BUFFER = 3'd0,
    S_RENDER      = 3'd1,
    S_DRAIN       = 3'd2,
    S_HOLD        = 3'd3,
    S_SWITCH      = 3'd4
  } state_t;

  localparam int IDLE_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [TIMER_WIDTH-1:0] C_PERIOD_LAST = TIMER_WIDTH'(FRAME_PERIOD - 1);
  localparam logic [TIMER_WIDTH-1:0] C_MIN_LAST    = TIMER_WIDTH'(MIN_PERIOD - 1);
  localparam logic [TIMER_WIDTH-1:0] C_TIMER_ONE   = TIMER_WIDTH'(1);
  localparam logic [TIMER_WIDTH-1:0] C_TIMER_MAX   = '1;
  localparam logic [IDLE_W-1:0]      C_IDLE_LAST   = IDLE_W'(DRAIN_CYCLES - 1);
  localparam logic [IDLE_W-1:0]      C_IDLE_ONE    = IDLE_W'(1);
  localparam logic [COUNT_WIDTH-1:0] C_COUNT_ONE   = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] C_COUNT_MAX   = '1;

  state_t                   r_state;
  logic                     r_mode;
  logic [TIMER_WIDTH-1:0]   r_timer;
  logic [IDLE_W-1:0]        r_idle;
  logic [COUNT_WIDTH-1:0]   r_pix_acc;
  logic                     r_fetch_rst;
  logic                     r_switch;
  logic [COUNT_WIDTH-1:0]   r_frame_cnt;
  logic [COUNT_WIDTH-1:0]   r_pix_cnt;
  logic [COUNT_WIDTH-1:0]   r_ovr_cnt;

  state_t                   w_next_state;
  logic                     w_pulse;
  logic                     w_complete;
  logic                     w_overrun;
  logic                     w_start;
  logic                     w_enter_drain;
  logic                     w_period_hit;
  logic                     w_min_hit;
  logic                     w_idle;
  logic                     w_drained;
  logic                     w_count_pixel;
  logic [COUNT_WIDTH-1:0]   w_acc_next;

  assign w_period_hit  = !r_mode && (r_timer == C_PERIOD_LAST);
  assign w_min_hit     = r_mode && (r_timer >= C_MIN_LAST);
  assign w_idle        = !pipeline_busy_in;
  assign w_drained     = w_idle && (r_idle == C_IDLE_LAST);
  assign w_count_pixel = pixel_valid_in &&
                         ((r_state == S_RENDER) || (r_state == S_DRAIN) || (r_state == S_HOLD));
  // Includes the pixel on the switching edge so the latched count is complete.
  assign w_acc_next    = (w_count_pixel && (r_pix_acc != C_COUNT_MAX)) ?
                         (r_pix_acc + C_COUNT_ONE) : r_pix_acc;

  always_comb begin
    w_next_state  = r_state;
    w_pulse       = 1'b0;
    w_complete    = 1'b0;
    w_overrun     = 1'b0;
    w_start       = 1'b0;
    w_enter_drain = 1'b0;
    case (r_state)
      S_WAIT_BUFFER: begin
        // A period expiry while idle still pulses so the display cadence holds.
        if (w_period_hit) begin
          w_pulse = 1'b1;
        end else if (framebuffer_ready_in) begin
          w_next_state = S_RENDER;
          w_start      = 1'b1;
        end
      end
      S_RENDER: begin
        if (w_period_hit) begin
          w_next_state = S_SWITCH;
          w_pulse      = 1'b1;
          w_overrun    = 1'b1;
        end else if (fetch_done_in) begin
          w_next_state  = S_DRAIN;
          w_enter_drain = 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_period_hit) begin
          w_next_state = S_SWITCH;
          w_pulse      = 1'b1;
          w_overrun    = 1'b1;
        end else if (w_drained) begin
          w_next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_period_hit || w_min_hit) begin
          w_next_state = S_SWITCH;
          w_pulse      = 1'b1;
          w_complete   = 1'b1;
        end
      end
      S_SWITCH: begin
        w_next_state = S_WAIT_BUFFER;
      end
      default: begin
        w_next_state = S_WAIT_BUFFER;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_WAIT_BUFFER;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_mode      <= 1'b0;
      r_timer     <= '0;
      r_idle      <= '0;
      r_pix_acc   <= '0;
      r_fetch_rst <= 1'b1;
      r_switch    <= 1'b0;
      r_frame_cnt <= '0;
      r_pix_cnt   <= '0;
      r_ovr_cnt   <= '0;
    end else begin
      if (w_start) begin
        r_mode <= mode_in;
      end

      if (w_pulse) begin
        r_timer <= '0;
      end else if (!(r_mode && (r_timer == C_TIMER_MAX))) begin
        r_timer <= r_timer + C_TIMER_ONE;
      end

      if (w_enter_drain) begin
        r_idle <= '0;
      end else if (r_state == S_DRAIN) begin
        if (!w_idle) begin
          r_idle <= '0;
        end else if (!w_drained) begin
          r_idle <= r_idle + C_IDLE_ONE;
        end
      end

      r_pix_acc <= w_start ? '0 : w_acc_next;

      if (w_complete) begin
        r_pix_cnt   <= w_acc_next;
        r_frame_cnt <= r_frame_cnt + C_COUNT_ONE;
      end

      if (w_overrun && (r_ovr_cnt != C_COUNT_MAX)) begin
        r_ovr_cnt <= r_ovr_cnt + C_COUNT_ONE;
      end

      r_fetch_rst <= (w_next_state == S_WAIT_BUFFER) || (w_next_state == S_SWITCH);
      r_switch    <= w_pulse;
    end
  end

  assign fetch_rst_out          = r_fetch_rst;
  assign framebuffer_switch_out = r_switch;
  assign framebuffer_clear_out  = r_switch;
  assign frame_count_out        = r_frame_cnt;
  assign pixel_count_out        = r_pix_cnt;
  assign overrun_count_out      = r_ovr_cnt;
  assign state_out              = r_state;

endmodule
`default_nettype wire
